draw_arbiter: RTL

- Shares the single VGA adapter pixel port among NREQ drawing engines (fillscreen, circle, Reuleaux triangle; each has a start/done handshake and a vga_x/vga_y/vga_colour/vga_plot output).
- Grants one engine at a time in round-robin order.
- Resets the granted engine, starts it, and routes its pixel stream to the adapter.
- On the engine's done, returns a one-cycle ack to the requester.
- Sits between the top-level scene controller and the engines.

---
 rtl/draw_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin owner of the VGA pixel port among NREQ drawing engines
// Optional watchdog abort enabled by defining DRAW_ARB_WATCHDOG_EN.
module draw_arbiter #(
  parameter int NREQ = 3,
  parameter int TO_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   eng_rst_n,
  output logic [NREQ-1:0]   eng_start,
  input  logic [NREQ-1:0]   eng_done,
  input  logic [8*NREQ-1:0] eng_x,
  input  logic [7*NREQ-1:0] eng_y,
  input  logic [3*NREQ-1:0] eng_colour,
  input  logic [NREQ-1:0]   eng_plot,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              busy,
  output logic [NREQ-1:0]   err
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TO_W < 2) begin : g_param_check
    $error("draw_arbiter: NREQ must be 2..8 and TO_W at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ENG_RST, S_RUN, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   last_q, last_d;
  logic [SW-1:0]   pick_idx;
  logic            pick_found;
  logic [NREQ-1:0] sel_oh;
  logic            wd_expire;
  logic            wd_fired;

  assign sel_oh = NREQ'(1) << sel_q;

  // First requester strictly after the last one served, wrapping at NREQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = SW'(idx);
      end
    end
  end

`ifdef DRAW_ARB_WATCHDOG_EN
  logic [TO_W-1:0] wd_q;
  logic            to_q;

  // Expiry is taken on the cycle the counter would reach all-ones.
  assign wd_expire = (state_q == S_RUN) && !eng_done[sel_q] &&
                     (wd_q == {{(TO_W-1){1'b1}}, 1'b0});
  assign wd_fired  = to_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (state_q == S_ENG_RST) begin
        wd_q <= '0;
      end else if (state_q == S_RUN) begin
        wd_q <= wd_q + 1'b1;
      end
      to_q <= wd_expire;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_fired  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= SW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    grant      = '0;
    eng_start  = '0;
    eng_rst_n  = '1;
    ack        = '0;
    err        = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          state_d = S_ENG_RST;
        end
      end
      S_ENG_RST: begin
        grant     = sel_oh;
        eng_rst_n = ~sel_oh;
        state_d   = S_RUN;
      end
      S_RUN: begin
        grant      = sel_oh;
        eng_start  = sel_oh;
        vga_x      = eng_x[8*int'(sel_q) +: 8];
        vga_y      = eng_y[7*int'(sel_q) +: 7];
        vga_colour = eng_colour[3*int'(sel_q) +: 3];
        vga_plot   = eng_plot[sel_q];
        if (eng_done[sel_q] || wd_expire) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        ack     = sel_oh;
        err     = wd_fired ? sel_oh : '0;
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset holds every engine in reset and silences the port immediately.
    if (!rst_n) begin
      grant      = '0;
      eng_start  = '0;
      eng_rst_n  = '0;
      ack        = '0;
      err        = '0;
      busy       = 1'b0;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
    end
  end

endmodule
